// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one 32-bit comparator between the
// branch unit (requester 0) and the SLT/SLTU execute path (requester 1).
// A grant latches the winner's operands, the compare is registered one
// cycle later, and the 1-bit result is held until the winner accepts it.
module cmp_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic        rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        gid_p0;
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic [2:0]  op_p0;
  logic [1:0]  grant;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_res;

  // SLT, BLT and BGE compare as two's complement; everything else unsigned.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b100) || (op == 3'b101);
  endfunction

  function automatic logic less_than(input logic [31:0] a, input logic [31:0] b,
                                     input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (sgn) return sa < sb;
    else     return a < b;
  endfunction

  // Map the funct3 code onto the eq/lt flags of the comparator.
  function automatic logic decode_result(input logic [2:0] op, input logic eq,
                                         input logic lt);
    case (op)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b010:  return lt;
      3'b011:  return lt;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      default: return !lt;
    endcase
  endfunction

  // Grant selection in IDLE: a lone request wins, a tie goes to the
  // requester that did not win last time.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Accept is combinational in the grant cycle; held low while in reset so
  // every output reads as its reset value without waiting for a clock.
  assign req_ready = grant & {2{rst_n}};

  // Shared comparator operating on the latched operands.
  assign cmp_eq  = (a_p0 == b_p0);
  assign cmp_lt  = less_than(a_p0, b_p0, is_signed_op(op_p0));
  assign cmp_res = decode_result(op_p0, cmp_eq, cmp_lt);

  // Control FSM with registered response outputs and operand latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gid_p0     <= 1'b0;
      a_p0       <= '0;
      b_p0       <= '0;
      op_p0      <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        // p0: grant and operand capture
        IDLE: begin
          if (grant != 2'b00) begin
            gid_p0     <= grant[1];
            last_grant <= grant[1];
            a_p0       <= grant[1] ? req1_a  : req0_a;
            b_p0       <= grant[1] ? req1_b  : req0_b;
            op_p0      <= grant[1] ? req1_op : req0_op;
            busy       <= 1'b1;
            state      <= EVAL;
          end
        end
        // p1: compare and register the result
        EVAL: begin
          rsp_result <= cmp_res;
          rsp_valid  <= gid_p0 ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        // p2: hold the response until the granted requester takes it
        RESP: begin
          if (rsp_ready[gid_p0]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed testbench for cmp_arbiter with hand-computed expectations.
module tb_cmp_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        rsp_result;
  logic        busy;

  int tests;
  int fails;

  cmp_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sweep_exp;
    logic [1:0] exp_rdy;
    logic [1:0] exp_vld;
    tests     = 0;
    fails     = 0;
    sweep_exp = 8'b1001_0110;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_a    = '0;
    req0_b    = '0;
    req0_op   = '0;
    req1_a    = '0;
    req1_b    = '0;
    req1_op   = '0;

    // Reset state
    tick();
    tick();
    #2;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_result", rsp_result, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;

    // Single request: req0 BLT -1 < 1
    tick();
    req_valid = 2'b01;
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_op = 3'b100;
    #2;
    check("blt_req_ready", req_ready, 2'b01);
    check("blt_busy_idle", busy, 1'b0);
    tick();
    req_valid = 2'b00;
    #2;
    check("blt_eval_ready", req_ready, 2'b00);
    check("blt_eval_rsp_valid", rsp_valid, 2'b00);
    check("blt_eval_busy", busy, 1'b1);
    tick();
    rsp_ready = 2'b01;
    #2;
    check("blt_rsp_valid", rsp_valid, 2'b01);
    check("blt_rsp_result", rsp_result, 1'b1);

    // Unsigned variant: req1 SLTU 0xFFFFFFFF < 1 is false
    tick();
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0001; req1_op = 3'b011;
    #2;
    check("sltu_idle_rsp_valid", rsp_valid, 2'b00);
    check("sltu_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b10;
    #2;
    check("sltu_rsp_valid", rsp_valid, 2'b10);
    check("sltu_rsp_result", rsp_result, 1'b0);
    tick();
    rsp_ready = 2'b00;

    // Tie sequence straight out of reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0_a = 32'h1234_5678; req0_b = 32'h1234_5678; req0_op = 3'b000;
    req1_a = 32'h1234_5678; req1_b = 32'h1234_5678; req1_op = 3'b000;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      #2;
      exp_rdy = 2'b00;
      exp_vld = 2'b00;
      if (k % 3 == 0) exp_rdy = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (k % 3 == 2) exp_vld = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("tie_req_ready_c%0d", k), req_ready, exp_rdy);
      check($sformatf("tie_rsp_valid_c%0d", k), rsp_valid, exp_vld);
      if (k % 3 == 2) check($sformatf("tie_rsp_result_c%0d", k), rsp_result, 1'b1);
    end
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Back-pressure: req0 BGEU 5,5 held for 4 cycles
    tick();
    req_valid = 2'b01;
    req0_a = 32'd5; req0_b = 32'd5; req0_op = 3'b111;
    #2;
    check("bp_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    req0_a = 32'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 2'b01;
      req0_a = 32'd3; req0_b = 32'd5;
      #2;
      check($sformatf("bp_rsp_valid_%0d", i), rsp_valid, 2'b01);
      check($sformatf("bp_rsp_result_%0d", i), rsp_result, 1'b1);
      check($sformatf("bp_req_ready_%0d", i), req_ready, 2'b00);
    end
    tick();
    rsp_ready = 2'b01;
    #2;
    check("bp_release_rsp_valid", rsp_valid, 2'b01);
    check("bp_release_rsp_result", rsp_result, 1'b1);
    tick();
    rsp_ready = 2'b00;
    #2;
    check("bp_pending_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b01;
    #2;
    check("bp_second_rsp_valid", rsp_valid, 2'b01);
    check("bp_second_rsp_result", rsp_result, 1'b0);
    tick();
    rsp_ready = 2'b00;

    // Full op sweep on req1: a=0x80000000, b=0x7FFFFFFF
    for (int op = 0; op < 8; op++) begin
      tick();
      req_valid = 2'b10;
      req1_a = 32'h8000_0000; req1_b = 32'h7FFF_FFFF; req1_op = 3'(op);
      #2;
      check($sformatf("sweep_req_ready_op%0d", op), req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      tick();
      rsp_ready = 2'b10;
      #2;
      check($sformatf("sweep_rsp_valid_op%0d", op), rsp_valid, 2'b10);
      check($sformatf("sweep_result_op%0d", op), rsp_result, sweep_exp[op]);
      tick();
      rsp_ready = 2'b00;
    end

    // Reset asserted during EVAL
    tick();
    req_valid = 2'b10;
    req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b000;
    #2;
    check("mid_rst_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #2;
    check("mid_rst_busy_eval", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 2'b00);
    check("mid_rst_rsp_result", rsp_result, 1'b0);
    check("mid_rst_req_ready", req_ready, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      check($sformatf("post_rst_rsp_valid_%0d", i), rsp_valid, 2'b00);
      check($sformatf("post_rst_busy_%0d", i), busy, 1'b0);
    end
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b11;
    req0_a = 32'd4; req0_b = 32'd4; req0_op = 3'b000;
    req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b000;
    #2;
    check("post_rst_tie_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b01;
    #2;
    check("post_rst_tie_rsp_valid", rsp_valid, 2'b01);
    check("post_rst_tie_rsp_result", rsp_result, 1'b1);
    tick();
    rsp_ready = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
